// File: rtl/mesh_out_port_arbiter_pkg.sv
// Shared mesh types: port directions, output-buffer states, packet header layout
// and the dimension-order route function used by every router output port.
package mesh_pkg;
   typedef enum logic [2:0] {
      DIR_N     = 3'd0,
      DIR_S     = 3'd1,
      DIR_E     = 3'd2,
      DIR_W     = 3'd3,
      DIR_LOCAL = 3'd4
   } dir_e;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

   // Offsets are relative to the header, i.e. the top HDR_W bits of a packet.
   localparam int NJ_W     = 8;
   localparam int COORD_W  = 4;
   localparam int HDR_W    = NJ_W + 2 * COORD_W + 1;
   localparam int NJ_LSB   = HDR_W - NJ_W;
   localparam int ROW_LSB  = NJ_LSB - COORD_W;
   localparam int COL_LSB  = ROW_LSB - COORD_W;
   localparam int MODE_BIT = 0;

   function automatic dir_e route_xy(input logic [HDR_W-1:0]   hdr,
                                     input logic [COORD_W-1:0] row_id,
                                     input logic [COORD_W-1:0] col_id,
                                     input logic [NJ_W-1:0]    bcast);
      logic [COORD_W-1:0] row;
      logic [COORD_W-1:0] col;
      dir_e               rdir;
      dir_e               cdir;
      row  = hdr[ROW_LSB +: COORD_W];
      col  = hdr[COL_LSB +: COORD_W];
      rdir = (row < row_id) ? DIR_N : DIR_S;
      cdir = (col < col_id) ? DIR_W : DIR_E;
      if (hdr[NJ_LSB +: NJ_W] == bcast) return DIR_LOCAL;
      if (row == row_id && col == col_id) return DIR_LOCAL;
      if (hdr[MODE_BIT]) return (col != col_id) ? cdir : rdir;
      return (row != row_id) ? rdir : cdir;
   endfunction
endpackage

// File: rtl/mesh_out_port_arbiter_if.sv
// Handshake bundle between an output-port arbiter, its input FIFO heads and the
// downstream consumer of the staged packets.
interface mesh_out_port_arbiter_if #(
   parameter int pckg_sz = 41,
   parameter int NUM_IN  = 5
) ();
   logic [NUM_IN-1:0]         pndng_i;
   logic [NUM_IN*pckg_sz-1:0] data_i;
   logic [NUM_IN-1:0]         pop_o;
   logic [pckg_sz-1:0]        data_out;
   logic                      pndng_o;
   logic                      popin;
   logic [15:0]               grant_cnt;

   modport master (output pndng_i, data_i, popin,
                   input  pop_o, data_out, pndng_o, grant_cnt);
   modport slave  (input  pndng_i, data_i, popin,
                   output pop_o, data_out, pndng_o, grant_cnt);
endinterface

// File: rtl/mesh_out_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer just past each winner.
module rr_arbiter #(
   parameter  int N     = 5,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     i_req,
   input  logic             i_enable,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_gnt_idx
);
   logic [IDX_W-1:0] r_ptr;
   logic             w_found;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      w_found   = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!w_found && i_req[IDX_W'((int'(r_ptr) + k) % N)]) begin
            w_found   = 1'b1;
            o_gnt_idx = IDX_W'((int'(r_ptr) + k) % N);
         end
      end
      if (w_found && i_enable) o_gnt[o_gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (|o_gnt) begin
         r_ptr <= (o_gnt_idx == IDX_W'(N - 1)) ? '0 : o_gnt_idx + IDX_W'(1);
      end
   end
endmodule

// File: rtl/mesh_out_port_arbiter.sv
// Output-port scheduler for one mesh router: routes each input FIFO head, grants one
// matching requester per cycle round-robin and stages winners in a 2-entry buffer.
module mesh_out_port_arbiter
   import mesh_pkg::*;
#(
   parameter int              pckg_sz = 41,
   parameter int              NUM_IN  = 5,
   parameter int              OUT_DIR = 0,
   parameter int              ROW_ID  = 1,
   parameter int              COL_ID  = 1,
   parameter logic [NJ_W-1:0] bdcst   = {8{1'b1}}
) (
   input  logic                   clk,
   input  logic                   reset,
   mesh_out_port_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   buf_state_e         r_state;
   buf_state_e         w_state_nxt;
   logic [pckg_sz-1:0] r_head;
   logic [pckg_sz-1:0] r_tail;
   logic [15:0]        r_gcnt;
   logic [NUM_IN-1:0]  w_req;
   logic [NUM_IN-1:0]  w_gnt;
   logic [IDX_W-1:0]   w_gnt_idx;
   logic [pckg_sz-1:0] w_din;
   logic               w_deq;
   logic               w_push;
   logic               w_accept;
   logic               w_ld_head;
   logic               w_shift;
   logic               w_ld_tail;

   // A packet never leaves through the port it came in on, except at the local port.
   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_req
      assign w_req[gi] = bus.pndng_i[gi]
                       && (int'(route_xy(bus.data_i[gi*pckg_sz + pckg_sz - 1 -: HDR_W],
                                         COORD_W'(ROW_ID), COORD_W'(COL_ID), bdcst)) == OUT_DIR)
                       && (gi != OUT_DIR || OUT_DIR == int'(DIR_LOCAL));
   end

   assign w_deq    = bus.popin && (r_state != BUF_EMPTY);
   assign w_accept = (r_state != BUF_FULL) || w_deq;

   rr_arbiter #(.N(NUM_IN)) u_rr (
      .clk       (clk),
      .reset     (reset),
      .i_req     (w_req),
      .i_enable  (w_accept),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx)
   );

   assign w_push        = |w_gnt;
   assign w_din         = bus.data_i[int'(w_gnt_idx)*pckg_sz +: pckg_sz];
   assign bus.pop_o     = w_gnt & {NUM_IN{~reset}};
   assign bus.data_out  = r_head;
   assign bus.pndng_o   = (r_state != BUF_EMPTY);
   assign bus.grant_cnt = r_gcnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= BUF_EMPTY;
      else       r_state <= w_state_nxt;
   end

   // Accept plus dequeue on one edge keeps occupancy; when full the tail moves up first.
   always_comb begin
      w_state_nxt = r_state;
      w_ld_head   = 1'b0;
      w_shift     = 1'b0;
      w_ld_tail   = 1'b0;
      case (r_state)
         BUF_EMPTY: begin
            if (w_push) begin
               w_ld_head   = 1'b1;
               w_state_nxt = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (w_push && !w_deq) begin
               w_ld_tail   = 1'b1;
               w_state_nxt = BUF_FULL;
            end else if (w_push) begin
               w_ld_head   = 1'b1;
            end else if (w_deq) begin
               w_state_nxt = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            if (w_deq) begin
               w_shift   = 1'b1;
               w_ld_tail = w_push;
               if (!w_push) w_state_nxt = BUF_ONE;
            end
         end
         default: w_state_nxt = BUF_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head <= '0;
         r_gcnt <= '0;
      end else begin
         if (w_shift)        r_head <= r_tail;
         else if (w_ld_head) r_head <= w_din;
         if (w_push)         r_gcnt <= r_gcnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_ld_tail) r_tail <= w_din;
   end
endmodule

// File: tb/tb_mesh_out_port_arbiter.sv
// Bench for mesh_out_port_arbiter: an E-output and a LOCAL-output port of router (1,1)
// see the same FIFO heads and are compared each cycle with a packet-level scoreboard.
module tb_mesh_out_port_arbiter;
   localparam int PW = 41;
   localparam int NI = 5;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mesh_out_port_arbiter_if #(.pckg_sz(PW), .NUM_IN(NI)) bus_e ();
   mesh_out_port_arbiter_if #(.pckg_sz(PW), .NUM_IN(NI)) bus_l ();

   mesh_out_port_arbiter #(.pckg_sz(PW), .NUM_IN(NI), .OUT_DIR(2), .ROW_ID(1), .COL_ID(1),
                           .bdcst(8'hFF)) dut_e (.clk(clk), .reset(reset), .bus(bus_e));
   mesh_out_port_arbiter #(.pckg_sz(PW), .NUM_IN(NI), .OUT_DIR(4), .ROW_ID(1), .COL_ID(1),
                           .bdcst(8'hFF)) dut_l (.clk(clk), .reset(reset), .bus(bus_l));

   logic [PW-1:0] pk [NI];
   logic [NI-1:0] pnd;
   logic          pin [2];
   int            n_vec = 0;
   int            n_err = 0;
   int            pops;
   logic [NI-1:0] ord [6];

   // scoreboard: per port an ordered list of up to two staged packets
   logic [PW-1:0] mbuf [2][2];
   int            mcnt [2];
   int            mptr [2];
   int            mgc  [2];
   int            mwin [2];

   logic [NI-1:0] s_pop [2];
   logic          s_pnd [2];
   logic [PW-1:0] s_dat [2];
   logic [15:0]   s_gc  [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] mk_pkt(input logic [7:0] nj, input logic [3:0] row,
                                            input logic [3:0] col, input logic mode,
                                            input logic [23:0] pl);
      return {nj, row, col, mode, pl};
   endfunction

   // Destination port of a packet at router (1,1): 0=N 1=S 2=E 3=W 4=LOCAL
   function automatic int ref_route(input logic [PW-1:0] p);
      int r;
      int c;
      r = int'(p[PW-9 -: 4]);
      c = int'(p[PW-13 -: 4]);
      if (p[PW-1 -: 8] == 8'hFF) return 4;
      if (p[PW-17] == 1'b0) begin
         if (r != 1) return (r < 1) ? 0 : 1;
         if (c != 1) return (c < 1) ? 3 : 2;
      end else begin
         if (c != 1) return (c < 1) ? 3 : 2;
         if (r != 1) return (r < 1) ? 0 : 1;
      end
      return 4;
   endfunction

   function automatic logic [PW-1:0] rnd_pkt();
      logic [7:0] nj;
      nj = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      return mk_pkt(nj, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 24'($urandom));
   endfunction

   task automatic drive(input logic [NI-1:0] p, input logic pe, input logic pl);
      pnd    = p;
      pin[0] = pe;
      pin[1] = pl;
      bus_e.pndng_i = p;
      bus_l.pndng_i = p;
      bus_e.popin   = pe;
      bus_l.popin   = pl;
      for (int i = 0; i < NI; i++) begin
         bus_e.data_i[i*PW +: PW] = pk[i];
         bus_l.data_i[i*PW +: PW] = pk[i];
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0;
         mptr[k] = 0;
         mgc[k]  = 0;
         mwin[k] = -1;
      end
   endtask

   task automatic model_check(input int k);
      int            od;
      logic [NI-1:0] req;
      logic [NI-1:0] exp_pop;
      logic          acc;
      od = (k == 0) ? 2 : 4;
      for (int i = 0; i < NI; i++)
         req[i] = pnd[i] && (ref_route(pk[i]) == od) && (i != od || od == 4);
      acc     = (mcnt[k] < 2) || pin[k];
      mwin[k] = -1;
      if (!reset && acc) begin
         for (int j = 0; j < NI; j++)
            if (mwin[k] < 0 && req[(mptr[k] + j) % NI]) mwin[k] = (mptr[k] + j) % NI;
      end
      exp_pop = '0;
      if (mwin[k] >= 0) exp_pop[mwin[k]] = 1'b1;
      chk($sformatf("pop_o[%0d]", k), 64'(s_pop[k]), 64'(exp_pop));
      chk($sformatf("pndng_o[%0d]", k), 64'(s_pnd[k]), 64'(mcnt[k] > 0));
      if (mcnt[k] > 0) chk($sformatf("data_out[%0d]", k), 64'(s_dat[k]), 64'(mbuf[k][0]));
      chk($sformatf("grant_cnt[%0d]", k), 64'(s_gc[k]), 64'(mgc[k]));
   endtask

   task automatic model_update(input int k);
      if (!reset) begin
         if (pin[k] && mcnt[k] > 0) begin
            mbuf[k][0] = mbuf[k][1];
            mcnt[k]--;
         end
         if (mwin[k] >= 0) begin
            mbuf[k][mcnt[k]] = pk[mwin[k]];
            mcnt[k]++;
            mptr[k] = (mwin[k] + 1) % NI;
            mgc[k]  = (mgc[k] + 1) % 65536;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      s_pop[0] = bus_e.pop_o;  s_pnd[0] = bus_e.pndng_o;
      s_dat[0] = bus_e.data_out; s_gc[0] = bus_e.grant_cnt;
      s_pop[1] = bus_l.pop_o;  s_pnd[1] = bus_l.pndng_o;
      s_dat[1] = bus_l.data_out; s_gc[1] = bus_l.grant_cnt;
      model_check(0);
      model_check(1);
      @(posedge clk);
      model_update(0);
      model_update(1);
      #1;
   endtask

   task automatic do_reset();
      drive('0, 1'b0, 1'b0);
      reset = 1'b1;
      model_reset();
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < NI; i++) pk[i] = '0;
      drive('0, 1'b0, 1'b0);
      model_reset();
      #1 reset = 1'b1;
      #1;
      chk("rst_pop", 64'(bus_e.pop_o), 64'd0);
      chk("rst_pndng", 64'(bus_e.pndng_o), 64'd0);
      chk("rst_data", 64'(bus_e.data_out), 64'd0);
      chk("rst_gcnt", 64'(bus_e.grant_cnt), 64'd0);
      cycle();
      reset = 1'b0;

      // single W packet to (1,3)
      pk[3] = mk_pkt(8'h00, 4'd1, 4'd3, 1'b0, 24'hA5A5A5);
      drive(5'b01000, 1'b1, 1'b1);
      cycle();
      chk("w_pop", 64'(s_pop[0]), 64'b01000);
      drive(5'b00000, 1'b1, 1'b1);
      cycle();
      chk("w_pndng", 64'(s_pnd[0]), 64'd1);
      chk("w_data", 64'(s_dat[0]), 64'(mk_pkt(8'h00, 4'd1, 4'd3, 1'b0, 24'hA5A5A5)));
      chk("w_gcnt", 64'(s_gc[0]), 64'd1);

      // N, S, LOCAL all heading east
      do_reset();
      pk[0] = mk_pkt(8'h00, 4'd1, 4'd3, 1'b0, 24'h000111);
      pk[1] = mk_pkt(8'h00, 4'd1, 4'd2, 1'b0, 24'h000222);
      pk[4] = mk_pkt(8'h00, 4'd1, 4'd3, 1'b1, 24'h000333);
      ord = '{5'b00001, 5'b00010, 5'b10000, 5'b00001, 5'b00010, 5'b10000};
      drive(5'b10011, 1'b1, 1'b1);
      for (int c = 0; c < 6; c++) begin
         cycle();
         chk($sformatf("rr_order%0d", c), 64'(s_pop[0]), 64'(ord[c]));
      end

      // backpressure: buffer fills after two grants, one popin admits one more
      do_reset();
      drive(5'b00001, 1'b0, 1'b1);
      pops = 0;
      for (int c = 0; c < 5; c++) begin
         cycle();
         if (s_pop[0] != '0) pops++;
      end
      chk("hold_pops", 64'(pops), 64'd2);
      chk("hold_idle", 64'(s_pop[0]), 64'd0);
      chk("hold_pndng", 64'(s_pnd[0]), 64'd1);
      drive(5'b00001, 1'b1, 1'b1);
      cycle();
      pops = (s_pop[0] != '0) ? 1 : 0;
      drive(5'b00001, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         cycle();
         if (s_pop[0] != '0) pops++;
      end
      chk("pulse_pops", 64'(pops), 64'd1);

      // U-turn suppressed, same packet from N is granted
      do_reset();
      pk[2] = mk_pkt(8'h00, 4'd1, 4'd3, 1'b0, 24'h0000EE);
      drive(5'b00100, 1'b1, 1'b1);
      pops = 0;
      for (int c = 0; c < 4; c++) begin
         cycle();
         if (s_pop[0] != '0) pops++;
      end
      chk("uturn_pops", 64'(pops), 64'd0);
      pk[0] = pk[2];
      drive(5'b00001, 1'b1, 1'b1);
      cycle();
      chk("uturn_from_n", 64'(s_pop[0]), 64'b00001);

      // mode bit and broadcast
      chk("route_mode0", 64'(ref_route(mk_pkt(8'h00, 4'd3, 4'd3, 1'b0, 24'd0))), 64'd1);
      chk("route_mode1", 64'(ref_route(mk_pkt(8'h00, 4'd3, 4'd3, 1'b1, 24'd0))), 64'd2);
      chk("route_bcast", 64'(ref_route(mk_pkt(8'hFF, 4'd3, 4'd3, 1'b0, 24'd0))), 64'd4);
      do_reset();
      pk[3] = mk_pkt(8'h00, 4'd3, 4'd3, 1'b0, 24'h00C0DE);
      drive(5'b01000, 1'b1, 1'b1);
      cycle();
      chk("mode0_pop", 64'(s_pop[0]), 64'd0);
      pk[3] = mk_pkt(8'h00, 4'd3, 4'd3, 1'b1, 24'h00C0DF);
      drive(5'b01000, 1'b1, 1'b1);
      cycle();
      chk("mode1_pop", 64'(s_pop[0]), 64'b01000);
      pk[4] = mk_pkt(8'hFF, 4'd3, 4'd3, 1'b0, 24'h00BCBC);
      drive(5'b10000, 1'b1, 1'b1);
      cycle();
      chk("bcast_pop_e", 64'(s_pop[0]), 64'd0);
      chk("bcast_pop_l", 64'(s_pop[1]), 64'b10000);

      // asynchronous reset with buffer full and a grant in flight
      do_reset();
      pk[3] = mk_pkt(8'h00, 4'd1, 4'd3, 1'b0, 24'h000777);
      drive(5'b01000, 1'b0, 1'b1);
      cycle();
      cycle();
      pk[1] = mk_pkt(8'h00, 4'd1, 4'd2, 1'b0, 24'h000888);
      pk[4] = mk_pkt(8'h00, 4'd1, 4'd3, 1'b0, 24'h000999);
      drive(5'b10010, 1'b1, 1'b1);
      #2;
      chk("pre_rst_pop", 64'(bus_e.pop_o), 64'b10000);
      reset = 1'b1;
      model_reset();
      #1;
      chk("midrst_pop", 64'(bus_e.pop_o), 64'd0);
      chk("midrst_pndng", 64'(bus_e.pndng_o), 64'd0);
      chk("midrst_data", 64'(bus_e.data_out), 64'd0);
      chk("midrst_gcnt", 64'(bus_e.grant_cnt), 64'd0);
      cycle();
      reset = 1'b0;
      cycle();
      chk("post_rst_first", 64'(s_pop[0]), 64'b00010);

      // random traffic with occasional resets
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NI; i++) pk[i] = rnd_pkt();
         drive(5'($urandom), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7));
         if (reset) begin
            reset = 1'b0;
         end else if ($urandom_range(0, 99) == 0) begin
            reset = 1'b1;
            model_reset();
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mesh_out_port_arbiter.md
Name: mesh_out_port_arbiter

Overview:
- Output-port scheduler for one router of the mesh_gnrtr ROWS x COLUMS mesh.
- Looks at the head packet of the NUM_IN input FIFOs (N, S, E, W, local).
- Computes each packet's route with dimension-order routing and grants one matching requester per cycle, round-robin.
- Pops the granted FIFO and stages packets in a 2-entry output buffer, which drives a pndng/pop handshake toward the downstream FIFO or the terminal.

Parameters:
- pckg_sz, 41, packet width in bits.
- NUM_IN, 5, number of input FIFOs. Index encoding: 0=N, 1=S, 2=E, 3=W, 4=LOCAL.
- OUT_DIR, 0, direction (same encoding) served by this instance.
- ROW_ID, 1, router row (row 1 is the north edge).
- COL_ID, 1, router column.
- bdcst, {8{1'b1}}, next-jump value that marks a broadcast packet.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pndng_i  in  NUM_IN  per-input FIFO non-empty flag; the FIFO is show-ahead (head data is valid while pndng is high)
- data_i  in  NUM_IN*pckg_sz  head packets; input i occupies bits [i*pckg_sz +: pckg_sz]
- pop_o  out  NUM_IN  one-cycle pop pulse to the granted input FIFO
- data_out  out  pckg_sz  head of the output buffer
- pndng_o  out  1  output buffer non-empty
- popin  in  1  downstream consumes data_out this cycle
- grant_cnt  out  16  packets granted since reset; wraps at 2^16

Behaviour:
- Packet fields:
  - [pckg_sz-1 -: 8] next jump
  - [pckg_sz-9 -: 4] destination row
  - [pckg_sz-13 -: 4] destination column
  - [pckg_sz-17] mode: 0 = row first, 1 = column first
  - remaining low bits: payload
- Route function, combinational, one per input:
  - Row first: dest row < ROW_ID -> N; dest row > ROW_ID -> S; otherwise dest col < COL_ID -> W, dest col > COL_ID -> E, equal -> LOCAL.
  - Column first: test columns before rows, same comparisons.
  - Next jump == bdcst -> LOCAL.
- req[i] = pndng_i[i] AND route(i) == OUT_DIR AND i != OUT_DIR. The no-U-turn rule does not apply when OUT_DIR == LOCAL, so req[4] is allowed for a local output.
- Buffer FSM states: EMPTY (cnt 0), ONE (cnt 1), FULL (cnt 2). A packet can be accepted when state != FULL, or when state == FULL and popin is high in the same cycle.
- Grant:
  - Round-robin pointer rr_ptr. Search starts at rr_ptr and covers rr_ptr..NUM_IN-1, then 0..rr_ptr-1.
  - Winner w: pop_o[w] = 1 in the same cycle (combinational from req, registered state).
  - At the clock edge: data_i[w] is written to the buffer tail, rr_ptr <= w+1 mod NUM_IN, grant_cnt increments.
  - With no grant, rr_ptr holds.
- Latency: a packet granted in cycle t appears on data_out with pndng_o=1 in cycle t+1 when the buffer was empty.
- popin with pndng_o=0 is ignored; count and pointers unchanged.
- Same-edge accept and popin: in EMPTY, no pop occurs (pndng_o=0). In ONE and FULL, occupancy is unchanged and FIFO order is preserved.
- At most one pop_o bit is high per cycle. pop_o is never high without a matching req.
- Reset, asynchronous and valid at any time including mid-transfer:
  - pop_o=0, pndng_o=0, data_out=0, grant_cnt=0, rr_ptr=0, state EMPTY.
  - Buffered packets are discarded.
  - pop_o deasserts immediately, combinationally gated by reset.

Decomposition:
- Shared package mesh_pkg holds:
  - direction enum dir_e (N, S, E, W, LOCAL)
  - packet field offset localparams
  - function route_xy(pkt, row_id, col_id) returning dir_e, reused by the scoreboard
- One sub-module, rr_arbiter #(N): inputs req and enable; outputs one-hot gnt and gnt_idx; owns rr_ptr.

Test Plan:
- OUT_DIR=E, ROW_ID=1, COL_ID=1; input W head dest (1,3) mode 0; popin=1 -> pop_o=5'b01000 for 1 cycle, then pndng_o=1 with the same packet next cycle, grant_cnt=1.
- Inputs N, S and LOCAL all route to E, held pending, popin=1 -> grant order N, S, LOCAL, N, S, LOCAL; one pop_o pulse per cycle.
- popin=0 with continuous requests -> exactly 2 pops, then pop_o=0 and pndng_o=1. A single popin pulse -> exactly one more pop.
- Input E head routes E (U-turn) -> req ignored, pop_o=0 forever. Same packet on N -> granted.
- Mode bit: dest (3,3), router (1,1). Mode 0 -> routes S; mode 1 -> routes E. Next jump 8'hFF -> routes LOCAL.
- Reset asserted with the buffer FULL and a request pending, between clock edges -> pndng_o=0, pop_o=0 immediately. After release, first grant goes to the lowest-index requester (rr_ptr=0).
